spi_regbank_sync: RTL and testbench
===================================

Name: spi_regbank_sync

Overview:
- Parametrised SPI-mode-0 peripheral and register bank that replaces the fixed 6×10-bit SCK-clocked register file.
- Oversamples SCK, CS_N and COPI in the system clock domain and decodes framed read/write transactions.
- Supports read-back of any register, plus read-only status registers fed from the buck datapath.
- Writes commit atomically on CS_N deassertion; control outputs are glitch-free in the clk domain.

Parameters:
- NUM_REGS, 8: number of registers; addresses 0..NUM_REGS-1.
- DATA_W, 10: bits per register.
- ADDR_W, 4: address field width; must satisfy 2**ADDR_W >= NUM_REGS.
- RO_MASK, 8'b1100_0000: bit i=1 makes register i read-only; its value comes from status_in.
- RESET_VAL, 0: reset value of every RW register (DATA_W bits).

Ports:
- clk  in  1  system clock; must be at least 8× SCK frequency.
- rst  in  1  reset, synchronous, active-low.
- sck  in  1  SPI clock, asynchronous to clk.
- cs_n  in  1  SPI chip select, active-low, asynchronous.
- copi  in  1  controller-out data.
- cipo  out  1  peripheral-out data.
- cipo_oe  out  1  high while a frame is active; drives the pad tri-state enable.
- status_in  in  NUM_REGS*DATA_W  read-only values; slice i is used when RO_MASK[i]=1.
- regs_out  out  NUM_REGS*DATA_W  flat register contents; RO slices read as 0.
- wr_strobe  out  1  one-cycle pulse when a write commits.
- wr_addr  out  ADDR_W  address of the last committed write; held between writes.
- wr_err  out  1  one-cycle pulse when a write is rejected (bad address or RO register).
- frame_err  out  1  one-cycle pulse when a frame has the wrong bit count.

Behaviour:
- Synchronisers: two-flop synchronisers on sck, cs_n and copi, followed by one edge-detect register.
  - Events: sck_rise, sck_fall, cs_fall, cs_rise, all in the clk domain.
  - Latency from pin to event is 3 clk cycles.
- Frame format, MSB first, FRAME_W = 1+ADDR_W+DATA_W bits (15 by default):
  - bit[FRAME_W-1] is RW (1=write, 0=read);
  - then ADDR_W address bits;
  - then DATA_W data bits.
- FSM states:
  - IDLE → SHIFT on cs_fall.
  - SHIFT → COMMIT on cs_rise.
  - COMMIT → IDLE after 1 cycle.
  - In IDLE, sck edges are ignored.
- Receive: in SHIFT, copi is sampled into rx_shift on each sck_rise. bit_cnt (width $clog2(FRAME_W+2)) increments and saturates at FRAME_W+1.
- Transmit:
  - When bit_cnt reaches 1+ADDR_W, tx_shift loads the current value of the addressed register. The value is status_in slice if RO, regfile if RW, 0 if address >= NUM_REGS.
  - On each following sck_fall, cipo presents the next tx_shift bit, MSB first. The first data bit is valid before the first data-phase sck rise.
  - cipo=0 outside the data phase.
  - cipo_oe=1 in SHIFT and 0 otherwise.
- Every frame returns the old register value (read-before-write), including write frames.
- COMMIT (the single cycle after cs_rise is detected):
  - bit_cnt != FRAME_W: frame_err=1, no write.
  - Else RW=1, addr < NUM_REGS and RO_MASK[addr]=0: regfile[addr] <= data, wr_strobe=1, wr_addr <= addr. The new value appears on regs_out the cycle after COMMIT.
  - Else RW=1 with bad address or RO target: wr_err=1, no write.
  - RW=0: no state change and no pulses.
- CS_N deasserted mid-frame: takes the COMMIT path with frame_err. Overlong frames (bit_cnt saturated at FRAME_W+1) also give frame_err.
- cs_fall while in COMMIT: recognised on the next cycle in IDLE. Back-to-back frames separated by at least 4 clk of CS_N high are never lost.
- Reset (rst=0 at posedge clk), including mid-frame:
  - FSM returns to IDLE; bit_cnt, rx_shift and tx_shift are cleared.
  - regfile = RESET_VAL; cipo=0, cipo_oe=0; all pulses 0; wr_addr=0.
  - A frame in progress is discarded. Decoding resumes at the next cs_fall after rst=1.

Optional Feature:
- Macro SPI_REGBANK_PARITY_EN.
- Defined:
  - FRAME_W grows by 1; the final bit is odd parity over RW, address and data.
  - Parity mismatch in COMMIT: no write, frame_err=1.
  - Read data returns DATA_W bits followed by one odd-parity bit over the data.
- Undefined: no parity bit; frame length and checks exactly as above.

Test Plan:
- Write frame RW=1, addr=1, data=0x2A5 (15 bits), then cs_n high → wr_strobe for 1 cycle, wr_addr=1, regs_out slice1=0x2A5 next cycle, no error pulses.
- Read frame addr=1 after the above → cipo shifts 10'b1010100101 on data-phase sck edges, cipo_oe=1 throughout, regfile unchanged.
- Write addr=6 (RO) with data=0x3FF, status_in slice6=0x155 → wr_err pulse, no wr_strobe. A following read of addr=6 returns 0x155.
- Write addr=9 (>= NUM_REGS) → wr_err pulse; read addr=9 returns 0x000.
- cs_n raised after 9 bits, and separately a 16-bit frame → frame_err pulse each time, all registers unchanged.
- rst=0 asserted mid-frame after 7 bits, released, then a full write addr=0, data=0x003 → regs_out slice0 transitions RESET_VAL→0x003, no spurious pulses during reset.

Source files
------------

// File: rtl/spi_regbank_sync.sv
// SPI mode-0 register bank, SCK/CS_N/COPI oversampled in the clk domain.
// Optional odd parity on frames and read data: define SPI_REGBANK_PARITY_EN.
module spi_regbank_sync #(
  parameter int                  NUM_REGS  = 8,
  parameter int                  DATA_W    = 10,
  parameter int                  ADDR_W    = 4,
  parameter logic [NUM_REGS-1:0] RO_MASK   = 8'b1100_0000,
  parameter logic [DATA_W-1:0]   RESET_VAL = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       sck,
  input  logic                       cs_n,
  input  logic                       copi,
  output logic                       cipo,
  output logic                       cipo_oe,
  input  logic [NUM_REGS*DATA_W-1:0] status_in,
  output logic [NUM_REGS*DATA_W-1:0] regs_out,
  output logic                       wr_strobe,
  output logic [ADDR_W-1:0]          wr_addr,
  output logic                       wr_err,
  output logic                       frame_err
);

`ifdef SPI_REGBANK_PARITY_EN
  localparam int PAR_W = 1;
`else
  localparam int PAR_W = 0;
`endif

  localparam int FRAME_W = 1 + ADDR_W + DATA_W + PAR_W;
  localparam int TX_W    = DATA_W + PAR_W;
  localparam int CNT_W   = $clog2(FRAME_W + 2);

  localparam logic [CNT_W-1:0] CNT_ADDR  = CNT_W'(ADDR_W);
  localparam logic [CNT_W-1:0] CNT_DLO   = CNT_W'(1 + ADDR_W);
  localparam logic [CNT_W-1:0] CNT_FRAME = CNT_W'(FRAME_W);
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(FRAME_W + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [2:0] sck_q;
  logic [2:0] cs_q;
  logic [1:0] copi_q;

  logic sck_rise, sck_fall;
  logic cs_rise, cs_fall;
  logic copi_s;

  logic [CNT_W-1:0]   bit_cnt_q;
  logic [FRAME_W-1:0] rx_q;
  logic [FRAME_W-1:0] rx_nx;
  logic [TX_W-1:0]    tx_q;
  logic [TX_W-1:0]    tx_load;
  logic               cipo_q;
  logic               pend_q;
  logic               start;

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] rd_data;
  logic [ADDR_W-1:0] rd_addr;

  logic              rx_rw;
  logic [ADDR_W-1:0] rx_addr;
  logic [DATA_W-1:0] rx_data;
  logic              wr_ok;
  logic              par_ok;

  logic              wr_strobe_q;
  logic              wr_err_q;
  logic              frame_err_q;
  logic [ADDR_W-1:0] wr_addr_q;

  // Synchronisers track the pins through reset so a held-low CS_N
  // cannot fake a cs_fall once reset is released.
  always_ff @(posedge clk) begin
    sck_q  <= {sck_q[1:0], sck};
    cs_q   <= {cs_q[1:0], cs_n};
    copi_q <= {copi_q[0], copi};
  end

  assign sck_rise = sck_q[1] & ~sck_q[2];
  assign sck_fall = ~sck_q[1] & sck_q[2];
  assign cs_rise  = cs_q[1] & ~cs_q[2];
  assign cs_fall  = ~cs_q[1] & cs_q[2];
  assign copi_s   = copi_q[1];

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (cs_fall || pend_q) state_d = SHIFT;
      SHIFT:   if (cs_rise) state_d = COMMIT;
      default: state_d = IDLE;
    endcase
  end

  assign start   = (state_q == IDLE) && (state_d == SHIFT);
  assign rx_nx   = {rx_q[FRAME_W-2:0], copi_s};
  assign rd_addr = rx_nx[ADDR_W-1:0];

  assign rx_rw   = rx_q[FRAME_W-1];
  assign rx_addr = rx_q[FRAME_W-2 -: ADDR_W];
  assign rx_data = rx_q[PAR_W +: DATA_W];

  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rd_addr == ADDR_W'(i)) begin
        rd_data = RO_MASK[i] ? status_in[i*DATA_W +: DATA_W]
                             : regs_q[i];
      end
    end
  end

  always_comb begin
    wr_ok = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rx_addr == ADDR_W'(i) && !RO_MASK[i]) wr_ok = 1'b1;
    end
  end

`ifdef SPI_REGBANK_PARITY_EN
  assign tx_load = {rd_data, ~^rd_data};
  assign par_ok  = ^rx_q;
`else
  assign tx_load = rd_data;
  assign par_ok  = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      bit_cnt_q   <= '0;
      rx_q        <= '0;
      tx_q        <= '0;
      cipo_q      <= 1'b0;
      pend_q      <= 1'b0;
      wr_strobe_q <= 1'b0;
      wr_err_q    <= 1'b0;
      frame_err_q <= 1'b0;
      wr_addr_q   <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= RESET_VAL;
    end else begin
      wr_strobe_q <= 1'b0;
      wr_err_q    <= 1'b0;
      frame_err_q <= 1'b0;
      pend_q      <= (state_q == COMMIT) && cs_fall;
      if (start) begin
        bit_cnt_q <= '0;
        rx_q      <= '0;
        tx_q      <= '0;
        cipo_q    <= 1'b0;
      end else if (state_q == SHIFT) begin
        if (sck_rise) begin
          rx_q <= rx_nx;
          if (bit_cnt_q != CNT_MAX) bit_cnt_q <= bit_cnt_q + 1'b1;
          if (bit_cnt_q == CNT_ADDR) tx_q <= tx_load;
        end
        if (sck_fall) begin
          if (bit_cnt_q >= CNT_DLO && bit_cnt_q < CNT_FRAME) begin
            cipo_q <= tx_q[TX_W-1];
            tx_q   <= tx_q << 1;
          end else begin
            cipo_q <= 1'b0;
          end
        end
      end else if (state_q == COMMIT) begin
        cipo_q <= 1'b0;
        if (bit_cnt_q != CNT_FRAME || !par_ok) begin
          frame_err_q <= 1'b1;
        end else if (rx_rw) begin
          if (wr_ok) begin
            wr_strobe_q <= 1'b1;
            wr_addr_q   <= rx_addr;
            for (int i = 0; i < NUM_REGS; i++) begin
              if (rx_addr == ADDR_W'(i)) regs_q[i] <= rx_data;
            end
          end else begin
            wr_err_q <= 1'b1;
          end
        end
      end else begin
        cipo_q <= 1'b0;
      end
    end
  end

  always_comb begin
    regs_out = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      regs_out[i*DATA_W +: DATA_W] = RO_MASK[i] ? '0 : regs_q[i];
    end
  end

  assign cipo_oe   = (state_q == SHIFT);
  assign cipo      = cipo_q & cipo_oe;
  assign wr_strobe = wr_strobe_q;
  assign wr_err    = wr_err_q;
  assign frame_err = frame_err_q;
  assign wr_addr   = wr_addr_q;

endmodule

// File: tb/tb_spi_regbank_sync.sv
// Directed bench for spi_regbank_sync (default build, no parity).
// Model keeps the register image; one negedge process compares every cycle.
module tb_spi_regbank_sync;

  localparam logic [7:0] RO = 8'b1100_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        sck = 1'b0;
  logic        cs_n = 1'b1;
  logic        copi = 1'b0;
  logic        cipo, cipo_oe;
  logic [79:0] status_in;
  logic [79:0] regs_out;
  logic        wr_strobe, wr_err, frame_err;
  logic [3:0]  wr_addr;

  spi_regbank_sync dut (
    .clk(clk), .rst(rst), .sck(sck), .cs_n(cs_n), .copi(copi),
    .cipo(cipo), .cipo_oe(cipo_oe), .status_in(status_in),
    .regs_out(regs_out), .wr_strobe(wr_strobe), .wr_addr(wr_addr),
    .wr_err(wr_err), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  logic [9:0] mreg [8];
  logic [3:0] mwaddr;
  logic       run = 1'b0;
  logic       busy = 1'b0;
  logic       settle = 1'b1;

  // slice7=0x0AB, slice6=0x155, RW slices carry junk that must be ignored
  assign status_in = {10'h0AB, 10'h155, 60'hFFF_FFFF_FFFF_FFFF};

  task automatic chk(input string nm, input logic [79:0] act,
                     input logic [79:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [79:0] exp_flat();
    logic [79:0] f;
    f = '0;
    for (int i = 0; i < 8; i++) f[i*10 +: 10] = RO[i] ? 10'h0 : mreg[i];
    return f;
  endfunction

  function automatic logic [9:0] model_read(input logic [3:0] a);
    if (a >= 4'd8) return 10'h0;
    if (RO[a[2:0]]) return status_in[a*10 +: 10];
    return mreg[a[2:0]];
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (run) begin
      if (!settle) begin
        chk("regs_out", regs_out, exp_flat());
        chk("wr_addr", 80'(wr_addr), 80'(mwaddr));
        chk("no_pulse", 80'({wr_strobe, wr_err, frame_err}), 80'(0));
      end
      if (!busy && !settle) chk("idle_pins", 80'({cipo_oe, cipo}), 80'(0));
    end
  end

  task automatic frame(input int nb, input logic [15:0] bits,
                       output logic [15:0] got);
    logic       rw;
    logic [3:0] a;
    logic [9:0] d, rd;
    logic       e_fe, e_we, e_ws;
    int         ns, ne, nf;
    logic [3:0] seen;
    got = '0;
    rw  = bits[nb-1];
    a   = (nb >= 5) ? bits[nb-2 -: 4] : 4'h0;
    d   = (nb >= 15) ? bits[nb-6 -: 10] : 10'h0;
    rd  = model_read(a);
    e_fe = (nb != 15);
    e_we = !e_fe && rw && !(a < 4'd8 && !RO[a[2:0]]);
    e_ws = !e_fe && rw && !e_we;
    busy = 1'b1;
    cs_n = 1'b0;
    tick(8);
    for (int i = nb - 1; i >= 0; i--) begin
      copi = bits[i];
      tick(4);
      chk("oe_in_frame", 80'(cipo_oe), 80'(1));
      got = {got[14:0], cipo};
      sck = 1'b1;
      tick(8);
      sck = 1'b0;
      tick(8);
    end
    copi = 1'b0;
    if (nb >= 15) chk("cipo_bits", 80'(got), 80'({6'b0, rd} << (nb - 15)));
    settle = 1'b1;
    cs_n = 1'b1;
    ns = 0; ne = 0; nf = 0; seen = 4'h0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      ns += int'(wr_strobe);
      ne += int'(wr_err);
      nf += int'(frame_err);
      if (wr_strobe) seen = wr_addr;
    end
    chk("wr_strobe_cnt", 80'(ns), 80'(e_ws));
    chk("wr_err_cnt", 80'(ne), 80'(e_we));
    chk("frame_err_cnt", 80'(nf), 80'(e_fe));
    if (e_ws) chk("wr_addr_pulse", 80'(seen), 80'(a));
    @(posedge clk);
    #1;
    if (e_ws) begin
      mreg[a[2:0]] = d;
      mwaddr = a;
    end
    settle = 1'b0;
    busy = 1'b0;
  endtask

  task automatic reset_midframe(input logic [6:0] bits);
    int np;
    busy = 1'b1;
    cs_n = 1'b0;
    tick(8);
    for (int i = 6; i >= 0; i--) begin
      copi = bits[i];
      tick(4);
      sck = 1'b1;
      tick(8);
      sck = 1'b0;
      tick(8);
    end
    settle = 1'b1;
    rst = 1'b0;
    np = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      np += int'(wr_strobe) + int'(wr_err) + int'(frame_err);
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    for (int i = 0; i < 8; i++) mreg[i] = 10'h0;
    mwaddr = 4'h0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      np += int'(wr_strobe) + int'(wr_err) + int'(frame_err);
    end
    chk("rst_oe_cs_low", 80'(cipo_oe), 80'(0));
    chk("rst_regs", regs_out, 80'h0);
    chk("rst_wr_addr", 80'(wr_addr), 80'(0));
    copi = 1'b0;
    cs_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      np += int'(wr_strobe) + int'(wr_err) + int'(frame_err);
    end
    chk("rst_pulses", 80'(np), 80'(0));
    @(posedge clk);
    #1;
    settle = 1'b0;
    busy = 1'b0;
  endtask

  logic [15:0] g;

  initial begin
    for (int i = 0; i < 8; i++) mreg[i] = 10'h0;
    mwaddr = 4'h0;
    tick(5);
    rst = 1'b1;
    tick(2);
    chk("reset_regs", regs_out, 80'h0);
    chk("reset_wr_addr", 80'(wr_addr), 80'(0));
    chk("reset_oe", 80'(cipo_oe), 80'(0));
    chk("reset_pulses", 80'({wr_strobe, wr_err, frame_err}), 80'(0));
    settle = 1'b0;
    run = 1'b1;
    tick(4);

    frame(15, {1'b0, 1'b1, 4'd1, 10'h2A5}, g);
    chk("lit_slice1", 80'(regs_out[19:10]), 80'h2A5);
    frame(15, {1'b0, 1'b0, 4'd1, 10'h000}, g);
    chk("lit_read1", 80'(g[9:0]), 80'(10'b1010100101));

    frame(15, {1'b0, 1'b1, 4'd6, 10'h3FF}, g);
    frame(15, {1'b0, 1'b0, 4'd6, 10'h000}, g);
    chk("lit_read6", 80'(g[9:0]), 80'h155);

    frame(15, {1'b0, 1'b1, 4'd9, 10'h3FF}, g);
    frame(15, {1'b0, 1'b0, 4'd9, 10'h000}, g);
    chk("lit_read9", 80'(g[9:0]), 80'h000);

    frame(9, {7'b0, 1'b1, 4'd2, 4'hF}, g);
    frame(16, {1'b1, 4'd3, 10'h111, 1'b1}, g);

    frame(15, {1'b0, 1'b1, 4'd5, 10'h1C7}, g);
    frame(15, {1'b0, 1'b1, 4'd0, 10'h3FF}, g);
    frame(15, {1'b0, 1'b1, 4'd5, 10'h0F0}, g);
    chk("lit_rbw5", 80'(g[9:0]), 80'h1C7);
    frame(15, {1'b0, 1'b0, 4'd7, 10'h000}, g);

    reset_midframe({1'b1, 4'd0, 2'b11});
    frame(15, {1'b0, 1'b1, 4'd0, 10'h003}, g);
    chk("lit_slice0", regs_out, 80'h3);

    tick(4);
    run = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: got running want done");
    $fatal(1, "timeout");
  end

endmodule
